// File: rtl/t_ff_array.sv
// t_ff_array: WIDTH-bit bank of T flip-flops.
// Modes: per-bit toggle, up/down count, hold, edge-triggered toggle.
module t_ff_array #(
   parameter int         WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit         SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] t,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             toggled
);

   typedef enum logic [1:0] {
      M_TOGGLE = 2'b00,
      M_COUNT  = 2'b01,
      M_HOLD   = 2'b10,
      M_EDGE   = 2'b11
   } mode_t;

   mode_t            mode_s;
   logic [WIDTH-1:0] t_prev;
   logic [WIDTH-1:0] tcnt;
   logic [WIDTH-1:0] q_next;
   logic             pu;
   logic             pd;

   assign mode_s = mode_t'(mode);

   // Count-mode T inputs: each bit toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      tcnt = '0;
      pu   = 1'b1;
      pd   = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         tcnt[i] = up ? pu : pd;
         pu      = pu & q[i];
         pd      = pd & ~q[i];
      end
   end

   // Terminal count is only meaningful while counting.
   always_comb begin
      tc = 1'b0;
      if (mode_s == M_COUNT)
         tc = up ? (&q) : (~|q);
   end

   // Next state: load beats enable, enable gates the mode rule.
   always_comb begin
      q_next = q;
      if (load) begin
         q_next = d;
      end else if (en) begin
         unique case (mode_s)
            M_TOGGLE: q_next = q ^ t;
            M_COUNT:  q_next = (SATURATE && tc) ? q : (q ^ tcnt);
            M_HOLD:   q_next = q;
            M_EDGE:   q_next = q ^ (t & ~t_prev);
            default:  q_next = q;
         endcase
      end
   end

   // State, change pulse and t history; t_prev tracks t every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= RESET_VAL;
         toggled <= 1'b0;
         t_prev  <= '0;
      end else begin
         q       <= q_next;
         toggled <= (q_next != q);
         t_prev  <= t;
      end
   end

endmodule

// File: tb/tb_t_ff_array.sv
// tb_t_ff_array: directed checks of t_ff_array (WIDTH=4),
// one wrapping instance and one saturating instance.
module tb_t_ff_array;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic [3:0] t;
   logic       up;
   logic       load;
   logic [3:0] d;
   logic [3:0] qa, qb;
   logic       tca, tcb, tga, tgb;

   int errors = 0;
   int checks = 0;

   t_ff_array #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .up(up),
      .load(load), .d(d), .q(qa), .tc(tca), .toggled(tga)
   );

   t_ff_array #(.WIDTH(4), .RESET_VAL(4'h0), .SATURATE(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t(t), .up(up),
      .load(load), .d(d), .q(qb), .tc(tcb), .toggled(tgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 2'b00; t = 4'h0;
      up = 1'b1; load = 1'b0; d = 4'h0;
      #2;
      chk("rst_q", qa, 4'h0);
      chk("rst_tg", {3'b0, tga}, 4'h0);
      chk("rst_tc", {3'b0, tca}, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // async reset between edges
      load = 1'b1; d = 4'hA;
      step();
      chk("load_a", qa, 4'hA);
      chk("load_a_tg", {3'b0, tga}, 4'h1);
      load = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_q", qa, 4'h0);
      chk("async_tg", {3'b0, tga}, 4'h0);
      chk("async_qb", qb, 4'h0);
      #1 rst_n = 1'b1;
      step();
      chk("post_rst_q", qa, 4'h0);
      chk("post_rst_tg", {3'b0, tga}, 4'h0);

      // TOGGLE
      en = 1'b1; mode = 2'b00; t = 4'b0101;
      step(); chk("tog1", qa, 4'h5); chk("tog1_tg", {3'b0, tga}, 4'h1);
      step(); chk("tog2", qa, 4'h0); chk("tog2_tg", {3'b0, tga}, 4'h1);
      step(); chk("tog3", qa, 4'h5); chk("tog3_tg", {3'b0, tga}, 4'h1);
      t = 4'h0;
      step(); chk("tog4", qa, 4'h5); chk("tog4_tg", {3'b0, tga}, 4'h0);
      chk("tog_tc", {3'b0, tca}, 4'h0);

      // COUNT wrap
      load = 1'b1; d = 4'hE;
      step(); chk("ld_e", qa, 4'hE);
      load = 1'b0; mode = 2'b01; up = 1'b1;
      #1 chk("cnt_tc_e", {3'b0, tca}, 4'h0);
      step(); chk("cnt_f", qa, 4'hF); chk("cnt_f_tc", {3'b0, tca}, 4'h1);
      step(); chk("cnt_0", qa, 4'h0); chk("cnt_0_tc", {3'b0, tca}, 4'h0);
      step(); chk("cnt_1", qa, 4'h1);
      up = 1'b0;
      step(); chk("dn_0", qa, 4'h0); chk("dn_0_tc", {3'b0, tca}, 4'h1);
      step(); chk("dn_f", qa, 4'hF); chk("dn_f_tc", {3'b0, tca}, 4'h0);

      // COUNT saturate
      load = 1'b1; d = 4'hE;
      step(); chk("ld_e_b", qb, 4'hE);
      load = 1'b0; up = 1'b1;
      step(); chk("sat_f", qb, 4'hF); chk("sat_f_tg", {3'b0, tgb}, 4'h1);
      chk("sat_f_tc", {3'b0, tcb}, 4'h1);
      step(); chk("sat_h1", qb, 4'hF); chk("sat_h1_tg", {3'b0, tgb}, 4'h0);
      step(); chk("sat_h2", qb, 4'hF); chk("sat_h2_tg", {3'b0, tgb}, 4'h0);
      chk("sat_h2_tc", {3'b0, tcb}, 4'h1);
      up = 1'b0;
      #1 chk("sat_dir_tc", {3'b0, tcb}, 4'h0);
      step(); chk("sat_dn_e", qb, 4'hE); chk("sat_dn_tg", {3'b0, tgb}, 4'h1);

      // EDGE
      load = 1'b1; d = 4'h0;
      step(); chk("ld_0", qa, 4'h0);
      load = 1'b0; mode = 2'b11; t = 4'b0100;
      step(); chk("edg1", qa, 4'h4); chk("edg1_tg", {3'b0, tga}, 4'h1);
      for (int i = 0; i < 4; i++) begin
         step(); chk("edg_lvl", qa, 4'h4);
      end
      chk("edg_lvl_tg", {3'b0, tga}, 4'h0);
      t = 4'h0;
      step(); chk("edg_low", qa, 4'h4);
      t = 4'b0100;
      step(); chk("edg2", qa, 4'h0);
      chk("edg_tc", {3'b0, tca}, 4'h0);
      t = 4'h0;
      step();
      en = 1'b0; t = 4'b0100;
      step(); chk("edg_en0", qa, 4'h0);
      en = 1'b1;
      step(); chk("edg_used", qa, 4'h0); chk("edg_used_tg", {3'b0, tga}, 4'h0);

      // priority
      t = 4'h0; load = 1'b1; d = 4'h9; en = 1'b0; mode = 2'b01;
      step(); chk("pri_ld", qa, 4'h9); chk("pri_ld_tg", {3'b0, tga}, 4'h1);
      step(); chk("pri_same", qa, 4'h9); chk("pri_same_tg", {3'b0, tga}, 4'h0);
      d = 4'h5; rst_n = 1'b0;
      step(); chk("pri_rst", qa, 4'h0); chk("pri_rst_tg", {3'b0, tga}, 4'h0);
      load = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(); chk("pri_rel", qa, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
